// File: rtl/adaptive_threshold_pkg.sv
// Shared encodings for the adaptive-thresholding pipeline: phase codes,
// binary pixel levels and the threshold-stage FSM states.
package adaptive_threshold_pkg;

  localparam logic [2:0] STATE_BOX_FILTER = 3'd1;
  localparam logic [2:0] STATE_THRESHOLD  = 3'd2;

  localparam logic [7:0] PIXEL_FG = 8'd255;
  localparam logic [7:0] PIXEL_BG = 8'd0;

  typedef enum logic [1:0] {
    FSM_RUN   = 2'd0,
    FSM_DRAIN = 2'd1,
    FSM_DONE  = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/adaptive_threshold_raster_counter.sv
// Raster-order pixel index with column/row split and a last-pixel flag;
// advances only when enabled, so the owner decides when to stop at the end.
module adaptive_threshold_raster_counter #(
  parameter int COL_BITS = 8,
  parameter int ROW_BITS = 8
) (
  input  logic                         clock,
  input  logic                         not_reset,
  input  logic                         i_enable,
  output logic [COL_BITS+ROW_BITS-1:0] o_pos,
  output logic [COL_BITS-1:0]          o_col,
  output logic [ROW_BITS-1:0]          o_row,
  output logic                         o_last
);

  localparam int POS_BITS = COL_BITS + ROW_BITS;

  logic [POS_BITS-1:0] r_pos;

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_pos <= '0;
    end else if (i_enable) begin
      r_pos <= r_pos + POS_BITS'(1);
    end
  end

  // Image dimensions are powers of two, so the last index is all ones.
  assign o_last = &r_pos;
  assign o_pos  = r_pos;
  assign o_col  = r_pos[COL_BITS-1:0];
  assign o_row  = r_pos[POS_BITS-1:COL_BITS];

endmodule

// File: rtl/adaptive_threshold.sv
// Threshold stage: streams pixel/mean pairs in raster order and writes a
// binary image, one pixel per clock, with a two-clock address-to-write latency.
module adaptive_threshold
  import adaptive_threshold_pkg::*;
#(
  parameter int         WIDTH_BITS  = 8,
  parameter int         HEIGHT_BITS = 8,
  parameter int         WIDTH       = 2**WIDTH_BITS,
  parameter int         HEIGHT      = 2**HEIGHT_BITS,
  parameter int         OFFSET      = 5,
  parameter bit         INVERT      = 1'b0,
  parameter logic [2:0] STATE_ID    = STATE_THRESHOLD
) (
  input  logic                   clock,
  input  logic                   not_reset,
  input  logic [2:0]             global_state,
  output logic [WIDTH_BITS-1:0]  oImageCol,
  output logic [HEIGHT_BITS-1:0] oImageRow,
  input  logic [7:0]             iImageData,
  output logic [WIDTH_BITS-1:0]  oMeanCol,
  output logic [HEIGHT_BITS-1:0] oMeanRow,
  input  logic [7:0]             iMeanData,
  output logic [WIDTH_BITS-1:0]  oResultCol,
  output logic [HEIGHT_BITS-1:0] oResultRow,
  output logic [7:0]             oResultData,
  output logic                   oResultWren,
  output logic                   finished
);

  localparam int                  POS_BITS = WIDTH_BITS + HEIGHT_BITS;
  localparam logic [POS_BITS-1:0] LAST_POS = POS_BITS'(WIDTH * HEIGHT - 1);
  localparam logic [8:0]          OFFSET_9 = 9'(OFFSET);

  fsm_state_t r_state;
  logic                   r_s1_valid;
  logic [POS_BITS-1:0]    r_s1_pos;
  logic [POS_BITS-1:0]    r_wr_pos;
  logic [7:0]             r_result_data;
  logic                   r_result_wren;
  logic                   r_finished;

  logic                   w_active;
  logic                   w_advance;
  logic                   w_rd_last;
  logic [POS_BITS-1:0]    w_rd_pos;
  logic [WIDTH_BITS-1:0]  w_rd_col;
  logic [HEIGHT_BITS-1:0] w_rd_row;
  logic [8:0]             w_sum;
  logic                   w_fg;
  logic [7:0]             w_cmp;

  assign w_active  = (global_state == STATE_ID);
  assign w_advance = (r_state == FSM_RUN) && w_active && !w_rd_last;

  adaptive_threshold_raster_counter #(
    .COL_BITS (WIDTH_BITS),
    .ROW_BITS (HEIGHT_BITS)
  ) u_rd_counter (
    .clock     (clock),
    .not_reset (not_reset),
    .i_enable  (w_advance),
    .o_pos     (w_rd_pos),
    .o_col     (w_rd_col),
    .o_row     (w_rd_row),
    .o_last    (w_rd_last)
  );

  // Stage 1: one address per active clock; the last one moves us to DRAIN
  // while its read is still in flight.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_state    <= FSM_RUN;
      r_s1_valid <= 1'b0;
      r_s1_pos   <= '0;
    end else begin
      case (r_state)
        FSM_RUN: begin
          r_s1_valid <= w_active;
          if (w_active) begin
            r_s1_pos <= w_rd_pos;
            if (w_rd_last) begin
              r_state <= FSM_DRAIN;
            end
          end
        end
        FSM_DRAIN: begin
          r_s1_valid <= 1'b0;
          if (r_s1_valid) begin
            r_state <= FSM_DONE;
          end
        end
        FSM_DONE: begin
          r_s1_valid <= 1'b0;
        end
        default: begin
          r_state    <= FSM_DONE;
          r_s1_valid <= 1'b0;
        end
      endcase
    end
  end

  // 9-bit sum so a large offset can never wrap past the mean.
  assign w_sum = {1'b0, iImageData} + OFFSET_9;
  assign w_fg  = (w_sum > {1'b0, iMeanData});
  assign w_cmp = (w_fg ^ INVERT) ? PIXEL_FG : PIXEL_BG;

  // Stage 2 runs regardless of phase so a read issued before a pause completes.
  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      r_result_wren <= 1'b0;
      r_result_data <= PIXEL_BG;
      r_wr_pos      <= '0;
      r_finished    <= 1'b0;
    end else begin
      r_result_wren <= r_s1_valid;
      r_wr_pos      <= r_s1_pos;
      if (r_s1_valid) begin
        r_result_data <= w_cmp;
      end
      if (r_result_wren && (r_wr_pos == LAST_POS)) begin
        r_finished <= 1'b1;
      end
    end
  end

  assign oImageCol   = w_rd_col;
  assign oImageRow   = w_rd_row;
  assign oMeanCol    = w_rd_col;
  assign oMeanRow    = w_rd_row;
  assign oResultCol  = r_wr_pos[WIDTH_BITS-1:0];
  assign oResultRow  = r_wr_pos[POS_BITS-1:WIDTH_BITS];
  assign oResultData = r_result_data;
  assign oResultWren = r_result_wren;
  assign finished    = r_finished;

endmodule

// File: tb/tb_adaptive_threshold.sv
// Bench for adaptive_threshold: two 4x4 instances (OFFSET=5 normal, OFFSET=255
// inverted) fed from shared image/mean memories and checked against a model.
module tb_adaptive_threshold;

  localparam int WB   = 2;
  localparam int HB   = 2;
  localparam int NPIX = 16;

  logic       clock = 1'b0;
  logic       not_reset = 1'b0;
  logic [2:0] global_state = 3'd1;

  logic [WB-1:0] img_col [2];
  logic [HB-1:0] img_row [2];
  logic [WB-1:0] mean_col [2];
  logic [HB-1:0] mean_row [2];
  logic [WB-1:0] res_col [2];
  logic [HB-1:0] res_row [2];
  logic [7:0]    res_data [2];
  logic [7:0]    img_q [2];
  logic [7:0]    mean_q [2];
  logic          wren [2];
  logic          fin [2];

  logic [7:0] img_mem [NPIX];
  logic [7:0] mean_mem [NPIX];

  int n_checks = 0;
  int n_errors = 0;
  int next_idx [2];
  int wr_count [2];
  bit fin_exp [2];

  always #5 clock = ~clock;

  adaptive_threshold #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .OFFSET(5), .INVERT(1'b0), .STATE_ID(3'd2)) dut0 (
    .clock(clock), .not_reset(not_reset), .global_state(global_state),
    .oImageCol(img_col[0]), .oImageRow(img_row[0]), .iImageData(img_q[0]),
    .oMeanCol(mean_col[0]), .oMeanRow(mean_row[0]), .iMeanData(mean_q[0]),
    .oResultCol(res_col[0]), .oResultRow(res_row[0]), .oResultData(res_data[0]),
    .oResultWren(wren[0]), .finished(fin[0])
  );

  adaptive_threshold #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .OFFSET(255), .INVERT(1'b1), .STATE_ID(3'd2)) dut1 (
    .clock(clock), .not_reset(not_reset), .global_state(global_state),
    .oImageCol(img_col[1]), .oImageRow(img_row[1]), .iImageData(img_q[1]),
    .oMeanCol(mean_col[1]), .oMeanRow(mean_row[1]), .iMeanData(mean_q[1]),
    .oResultCol(res_col[1]), .oResultRow(res_row[1]), .oResultData(res_data[1]),
    .oResultWren(wren[1]), .finished(fin[1])
  );

  // Synchronous-read memories, one clock of latency.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      img_q[i]  <= img_mem[{img_row[i], img_col[i]}];
      mean_q[i] <= mean_mem[{mean_row[i], mean_col[i]}];
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_pix(input int pix, input int mean, input int inst);
    int off = (inst == 0) ? 5 : 255;
    bit fg  = (pix + off) > mean;
    if (inst == 1) fg = !fg;
    return fg ? 255 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      next_idx[i] = 0;
      wr_count[i] = 0;
      fin_exp[i]  = 1'b0;
    end
  endtask

  // Every write must be the next raster index carrying the modelled value.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("finished%0d", i), int'(fin[i]), int'(fin_exp[i]));
      if (wren[i]) begin
        if (next_idx[i] < NPIX) begin
          check($sformatf("wr_idx%0d", i), int'({res_row[i], res_col[i]}), next_idx[i]);
          check($sformatf("wr_data%0d_idx%0d", i, next_idx[i]), int'(res_data[i]),
                ref_pix(int'(img_mem[next_idx[i]]), int'(mean_mem[next_idx[i]]), i));
          if (i == 0)
            $display("write idx %0d data %0d", next_idx[i], res_data[i]);
          if (next_idx[i] == NPIX - 1) fin_exp[i] = 1'b1;
        end else begin
          check($sformatf("extra_wr%0d", i), int'(wren[i]), 0);
        end
        next_idx[i]++;
        wr_count[i]++;
      end
    end
  end

  task automatic fill(input int mode);
    int ep [8] = '{95, 96, 0, 0, 0, 1, 255, 200};
    int em [8] = '{100, 100, 0, 255, 254, 254, 255, 0};
    int p, m;
    for (int k = 0; k < NPIX; k++) begin
      if (mode == 0) begin
        img_mem[k]  = 8'd100;
        mean_mem[k] = 8'd100;
      end else begin
        p = $urandom_range(0, 255);
        if ($urandom_range(0, 1) == 1) begin
          m = p + $urandom_range(0, 10);
          if (m > 255) m = 255;
        end else begin
          m = $urandom_range(0, 255);
        end
        img_mem[k]  = 8'(p);
        mean_mem[k] = 8'(m);
      end
    end
    if (mode == 1) begin
      for (int k = 0; k < 8; k++) begin
        img_mem[k]  = 8'(ep[k]);
        mean_mem[k] = 8'(em[k]);
      end
    end
    if (mode == 2) begin
      img_mem[9]  = 8'd200;
      mean_mem[9] = 8'd0;
    end
  endtask

  task automatic restart(input int mode);
    @(negedge clock);
    #1 not_reset = 1'b0;
    model_reset();
    fill(mode);
    @(negedge clock);
    #1 not_reset = 1'b1;
  endtask

  task automatic wait_finished(input int budget, input string tag);
    int n = 0;
    while (!(fin[0] && fin[1]) && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_finished"}, int'(fin[0] && fin[1]), 1);
    check({tag, "_count0"}, wr_count[0], NPIX);
    check({tag, "_count1"}, wr_count[1], NPIX);
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_wren"}, int'(wren[i]), 0);
      check({tag, "_data"}, int'(res_data[i]), 0);
      check({tag, "_fin"}, int'(fin[i]), 0);
      check({tag, "_res_addr"}, int'({res_row[i], res_col[i]}), 0);
      check({tag, "_rd_addr"}, int'({img_row[i], img_col[i]}), 0);
    end
  endtask

  initial begin
    int n;
    model_reset();
    fill(0);
    repeat (2) @(negedge clock);
    check_zero_outputs("reset");

    // Uniform image, state held active; first write two clocks after the first address.
    #1 not_reset = 1'b1;
    global_state = 3'd2;
    @(negedge clock);
    check("latency_1clk_wren", int'(wren[0]), 0);
    @(negedge clock);
    check("latency_2clk_wren", int'(wren[0]), 1);
    wait_finished(100, "uniform");
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      check("done_wren", int'(wren[0]), 0);
      check("done_rd_addr", int'({img_row[0], img_col[0]}), NPIX - 1);
      check("done_fin", int'(fin[0]), 1);
    end

    // Threshold edge values plus a 3-clock pause after index 5 issues.
    restart(1);
    n = 0;
    while (int'({img_row[0], img_col[0]}) != 5 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("pause_reach_idx5", int'({img_row[0], img_col[0]}), 5);
    @(negedge clock);
    #1 global_state = 3'd1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("pause_rd_addr", int'({img_row[0], img_col[0]}), 6);
      if (k > 0) check("pause_wren", int'(wren[0]), 0);
    end
    #1 global_state = 3'd2;
    wait_finished(100, "pause");

    // Asynchronous reset while index 9 is being written.
    restart(2);
    n = 0;
    while (!(wren[0] && int'({res_row[0], res_col[0]}) == 9) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("reach_write9", int'(wren[0]), 1);
    #1 not_reset = 1'b0;
    model_reset();
    #1 check_zero_outputs("midreset");
    fill(3);
    @(negedge clock);
    #1 not_reset = 1'b1;
    wait_finished(100, "after_reset");

    // Random images with random pauses and foreign phase codes.
    for (int r = 0; r < 4; r++) begin
      restart(3);
      n = 0;
      while (!(fin[0] && fin[1]) && n < 300) begin
        @(negedge clock);
        #1 global_state = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
        n++;
      end
      global_state = 3'd2;
      wait_finished(10, $sformatf("random%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
